// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Load-use / branch / MDU / memory-wait sequencing for the 5-stage core
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int MAX_WAIT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt_dst,
  input  logic       i_id_is_mdu,
  input  logic       i_id_mdu_div,
  input  logic       i_id_reads_hilo,
  input  logic       i_ex_branch_taken,
  input  logic       i_mem_req,
  input  logic       i_mem_ready,
  output logic       o_pc_we,
  output logic       o_ifid_we,
  output logic       o_idex_we,
  output logic       o_exmem_we,
  output logic       o_ifid_flush,
  output logic       o_idex_bubble,
  output logic       o_memwb_bubble,
  output logic       o_mdu_start,
  output logic       o_mdu_busy,
  output logic       o_mdu_done,
  output logic       o_mem_timeout,
  output logic [1:0] o_state
);

  localparam int c_MAX_LAT = (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
  localparam int c_WAIT_W  = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] c_RUN      = 2'b00;
  localparam logic [1:0] c_MEM_WAIT = 2'b01;
  localparam logic [1:0] c_HALT     = 2'b10;

  localparam logic [c_CNT_W-1:0]  c_MUL_CNT   = c_CNT_W'(MUL_LATENCY);
  localparam logic [c_CNT_W-1:0]  c_DIV_CNT   = c_CNT_W'(DIV_LATENCY);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [c_WAIT_W-1:0] r_wait;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic                r_timeout;
  logic                w_timeout_nxt;
  logic [c_CNT_W-1:0]  r_mdu_cnt;

  logic w_freeze;
  logic w_load_use;
  logic w_mdu_busy;
  logic w_mdu_stall;
  logic w_mdu_start;

  assign w_freeze = ((r_state == c_RUN) && i_mem_req && !i_mem_ready) ||
                    ((r_state == c_MEM_WAIT) && !i_mem_ready) ||
                    (r_state == c_HALT);

  assign w_load_use = i_ex_mem_read && (i_ex_rt_dst != 5'd0) &&
                      ((i_ex_rt_dst == i_id_rs) || (i_id_uses_rt && (i_ex_rt_dst == i_id_rt)));

  assign w_mdu_busy  = (r_mdu_cnt != '0);
  assign w_mdu_stall = w_mdu_busy && (i_id_reads_hilo || i_id_is_mdu);
  assign w_mdu_start = i_id_is_mdu && !w_mdu_busy && !w_freeze &&
                       !i_ex_branch_taken && !w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= c_RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wait    <= w_wait_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // wait_cnt counts consecutive frozen cycles; the last allowed one trips HALT
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait;
    w_timeout_nxt = r_timeout;
    case (r_state)
      c_RUN: begin
        if (i_mem_req && !i_mem_ready) begin
          w_state_nxt = c_MEM_WAIT;
          w_wait_nxt  = c_WAIT_W'(1);
        end
      end
      c_MEM_WAIT: begin
        if (i_mem_ready) begin
          w_state_nxt = c_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait == c_WAIT_LAST) begin
          w_state_nxt   = c_HALT;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_nxt = r_wait + c_WAIT_W'(1);
        end
      end
      c_HALT: begin
        w_state_nxt = c_HALT;
      end
      default: begin
        w_state_nxt = c_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // The MDU keeps counting through freezes; it is independent of the pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdu_cnt <= '0;
    end else if (w_mdu_start) begin
      r_mdu_cnt <= i_id_mdu_div ? c_DIV_CNT : c_MUL_CNT;
    end else if (w_mdu_busy) begin
      r_mdu_cnt <= r_mdu_cnt - c_CNT_W'(1);
    end
  end

  always_comb begin
    o_pc_we        = 1'b0;
    o_ifid_we      = 1'b0;
    o_idex_we      = 1'b0;
    o_exmem_we     = 1'b0;
    o_ifid_flush   = 1'b1;
    o_idex_bubble  = 1'b1;
    o_memwb_bubble = 1'b1;
    o_mdu_start    = 1'b0;
    o_mdu_busy     = 1'b0;
    o_mdu_done     = 1'b0;
    o_mem_timeout  = r_timeout;
    o_state        = 2'b00;
    if (rst_n) begin
      o_state        = r_state;
      o_mdu_busy     = w_mdu_busy;
      o_mdu_done     = (r_mdu_cnt == c_CNT_W'(1));
      o_mdu_start    = w_mdu_start;
      o_memwb_bubble = w_freeze;
      o_idex_we      = !w_freeze;
      o_exmem_we     = !w_freeze;
      o_ifid_flush   = 1'b0;
      o_idex_bubble  = 1'b0;
      if (!w_freeze) begin
        if (i_ex_branch_taken) begin
          o_pc_we       = 1'b1;
          o_ifid_we     = 1'b1;
          o_ifid_flush  = 1'b1;
          o_idex_bubble = 1'b1;
        end else if (w_load_use || w_mdu_stall) begin
          o_idex_bubble = 1'b1;
        end else begin
          o_pc_we   = 1'b1;
          o_ifid_we = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed + randomized bench for hazard_stall_ctrl against a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;
  localparam int MAXW  = 4;

  // Vector order: pc,ifid,idex,exmem,flush,bubble,memwb,start,busy,done,timeout,state[1:0]
  localparam logic [12:0] c_RST  = 13'b0000111000000;
  localparam logic [12:0] c_IDLE = 13'b1111000000000;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rt_dst;
  logic       id_uses_rt, ex_mem_read, id_is_mdu, id_mdu_div, id_reads_hilo;
  logic       br, mem_req, mem_ready;
  logic       pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble;
  logic       mdu_start, mdu_busy, mdu_done, mem_timeout;
  logic [1:0] state;
  logic [12:0] w_dut;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: consecutive frozen-cycle count, halt flag, MDU cycles remaining
  int m_run;
  bit m_halt;
  int m_cnt;

  hazard_stall_ctrl #(.MUL_LATENCY(MUL_L), .DIV_LATENCY(DIV_L), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rt(id_uses_rt),
    .i_ex_mem_read(ex_mem_read), .i_ex_rt_dst(ex_rt_dst),
    .i_id_is_mdu(id_is_mdu), .i_id_mdu_div(id_mdu_div), .i_id_reads_hilo(id_reads_hilo),
    .i_ex_branch_taken(br), .i_mem_req(mem_req), .i_mem_ready(mem_ready),
    .o_pc_we(pc_we), .o_ifid_we(ifid_we), .o_idex_we(idex_we), .o_exmem_we(exmem_we),
    .o_ifid_flush(ifid_flush), .o_idex_bubble(idex_bubble), .o_memwb_bubble(memwb_bubble),
    .o_mdu_start(mdu_start), .o_mdu_busy(mdu_busy), .o_mdu_done(mdu_done),
    .o_mem_timeout(mem_timeout), .o_state(state)
  );

  assign w_dut = {pc_we, ifid_we, idex_we, exmem_we, ifid_flush, idex_bubble, memwb_bubble,
                  mdu_start, mdu_busy, mdu_done, mem_timeout, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit model_freeze();
    return m_halt || (m_run > 0 && !mem_ready) || (m_run == 0 && mem_req && !mem_ready);
  endfunction

  function automatic logic [12:0] model_out();
    bit fr, lu, ms, st, busy, done;
    logic [1:0] s;
    if (!rst_n) return c_RST;
    fr   = model_freeze();
    lu   = ex_mem_read && ex_rt_dst != 0 &&
           (ex_rt_dst == id_rs || (id_uses_rt && ex_rt_dst == id_rt));
    busy = m_cnt > 0;
    done = m_cnt == 1;
    ms   = busy && (id_reads_hilo || id_is_mdu);
    st   = id_is_mdu && !busy && !fr && !br && !lu;
    s    = m_halt ? 2'b10 : (m_run > 0 ? 2'b01 : 2'b00);
    if (fr)
      return {4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, busy, done, m_halt, s};
    else if (br)
      return {4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, busy, done, m_halt, s};
    else if (lu || ms)
      return {4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, busy, done, m_halt, s};
    else
      return {4'b1111, 1'b0, 1'b0, 1'b0, st, busy, done, m_halt, s};
  endfunction

  task automatic model_reset();
    m_run = 0; m_halt = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [12:0] e;
    bit fr;
    e  = model_out();
    fr = model_freeze();
    if (e[5]) m_cnt = id_mdu_div ? DIV_L : MUL_L;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    if (!m_halt) begin
      if (fr) begin
        m_run = m_run + 1;
        if (m_run == MAXW) m_halt = 1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 0; ex_mem_read = 0; ex_rt_dst = 5'd0;
    id_is_mdu = 0; id_mdu_div = 0; id_reads_hilo = 0; br = 0; mem_req = 0; mem_ready = 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic lit(input string name, input logic [12:0] exp);
    #1;
    n_tests++;
    if (w_dut !== exp) begin
      n_fail++;
      $display("FAIL %s: dut=%b expected=%b", name, w_dut, exp);
    end
    n_tests++;
    if (model_out() !== exp) begin
      n_fail++;
      $display("FAIL %s_model: model=%b expected=%b", name, model_out(), exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    n_tests++;
    if (w_dut !== model_out()) begin
      n_fail++;
      $display("FAIL cycle@%0t: dut=%b model=%b", $time, w_dut, model_out());
    end
  end

  task automatic mdu_run(input string name, input bit div, input int lat);
    int nbusy, nstall, done_at, nstart;
    cyc(); idle(); id_is_mdu = 1; id_mdu_div = div;
    lit({name, "_start"}, 13'b1111000100000);
    nbusy = 0; nstall = 0; done_at = -1; nstart = 0;
    for (int k = 1; k <= lat + 3; k++) begin
      cyc(); idle(); id_reads_hilo = 1;
      #1;
      if (mdu_busy) nbusy++;
      if (!pc_we && idex_bubble) nstall++;
      if (mdu_done) done_at = k;
      if (mdu_start) nstart++;
    end
    check_int({name, "_busy_cycles"}, nbusy, lat);
    check_int({name, "_stall_cycles"}, nstall, lat);
    check_int({name, "_done_at"}, done_at, lat);
    check_int({name, "_restarts"}, nstart, 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    cyc(); cyc();
    lit("reset", c_RST);
    cyc(); rst_n = 1;
    lit("idle", c_IDLE);

    cyc(); ex_mem_read = 1; ex_rt_dst = 5'd5; id_rs = 5'd5;
    lit("load_use_rs", 13'b0011010000000);
    cyc(); ex_rt_dst = 5'd0; id_rs = 5'd0;
    lit("load_use_r0", c_IDLE);
    cyc(); ex_rt_dst = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1;
    lit("load_use_rt", 13'b0011010000000);
    cyc(); id_uses_rt = 0;
    lit("rt_unused", c_IDLE);
    cyc(); id_rs = 5'd5; br = 1; id_is_mdu = 1;
    lit("branch_over_stall", 13'b1111110000000);

    mdu_run("mul", 1'b0, MUL_L);
    mdu_run("div", 1'b1, DIV_L);

    cyc(); idle(); mem_req = 1; mem_ready = 0;
    lit("memwait0", 13'b0000001000000);
    cyc();
    lit("memwait1", 13'b0000001000001);
    cyc(); br = 1; ex_mem_read = 1; ex_rt_dst = 5'd1;
    lit("memwait_freeze_wins", 13'b0000001000001);
    cyc(); mem_ready = 1;
    lit("memwait_release", 13'b1111110000001);
    cyc(); idle();
    lit("memwait_after", c_IDLE);

    cyc(); mem_req = 1; mem_ready = 0;
    lit("to_f0", 13'b0000001000000);
    for (int k = 1; k < MAXW; k++) begin
      cyc();
      lit("to_fn", 13'b0000001000001);
    end
    cyc();
    lit("halt", 13'b0000001000110);
    cyc(); mem_ready = 1; mem_req = 0;
    lit("halt_hold", 13'b0000001000110);
    cyc(); rst_n = 0; model_reset();
    lit("halt_reset", c_RST);
    cyc(); rst_n = 1; idle();
    lit("halt_released", c_IDLE);

    cyc(); id_is_mdu = 1; id_mdu_div = 1;
    lit("div2_start", 13'b1111000100000);
    for (int k = 1; k <= 16; k++) begin
      cyc(); idle();
    end
    lit("div_cnt17", 13'b1111000010000);
    rst_n = 0; model_reset();
    lit("reset_mid_div", c_RST);
    cyc(); rst_n = 1;
    lit("after_mid_reset", c_IDLE);

    for (int i = 0; i < 4000; i++) begin
      cyc();
      if (!rst_n) rst_n = 1;
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_rt_dst     = 5'($urandom_range(0, 3));
      id_uses_rt    = ($urandom_range(0, 1) == 1);
      ex_mem_read   = ($urandom_range(0, 9) < 3);
      id_is_mdu     = ($urandom_range(0, 9) < 2);
      id_mdu_div    = ($urandom_range(0, 3) == 0);
      id_reads_hilo = ($urandom_range(0, 9) < 2);
      br            = ($urandom_range(0, 19) < 3);
      mem_req       = ($urandom_range(0, 9) < 3);
      mem_ready     = ($urandom_range(0, 3) != 0);
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        rst_n = 0;
        model_reset();
      end
    end

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding logic in the ID/EX boundary.
- Resolves hazards forwarding cannot cover:
  - load-use stalls;
  - taken-branch flushes;
  - interlocks against the multi-cycle multiply/divide unit (MDU);
  - whole-pipeline freezes while the data memory is not ready, with a timeout that halts the core.
- Drives every pipeline-register write enable and bubble/flush control, plus the MDU start pulse.

## Interface
- MUL_LATENCY, 4: MDU cycles for mult/multu.
- DIV_LATENCY, 32: MDU cycles for div/divu.
- MAX_WAIT, 64: consecutive not-ready memory cycles before HALT (≥2).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt_dst  in  5  load destination register in EX.
- id_is_mdu  in  1  ID instruction is mult/div.
- id_mdu_div  in  1  1 = div, 0 = mult (valid with id_is_mdu).
- id_reads_hilo  in  1  ID instruction is mfhi/mflo.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM-stage load/store active.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  stage register write enables.
- ifid_flush, idex_bubble, memwb_bubble  out  1 each  insert NOP into IF/ID, ID/EX, MEM/WB.
- mdu_start  out  1  one-cycle MDU launch.
- mdu_busy  out  1  MDU counter non-zero.
- mdu_done  out  1  one-cycle pulse on MDU completion.
- mem_timeout  out  1  sticky error.
- state  out  2  00 RUN, 01 MEM_WAIT, 10 HALT.

## Operation
- FSM:
  - RUN → MEM_WAIT when mem_req & ~mem_ready; wait_cnt ← 1.
  - MEM_WAIT → RUN when mem_ready; wait_cnt ← 0.
  - MEM_WAIT with ~mem_ready: wait_cnt increments. When wait_cnt == MAX_WAIT−1, the FSM moves to HALT and sets mem_timeout.
  - HALT is terminal until reset.
- freeze = (RUN & mem_req & ~mem_ready) | (MEM_WAIT & ~mem_ready) | HALT.
- While freeze is high:
  - pc_we, ifid_we, idex_we, exmem_we = 0.
  - memwb_bubble = 1.
  - ifid_flush and idex_bubble = 0.
  - mdu_start = 0.
  - Branch and stall conditions are ignored.
- load_use = ex_mem_read & ex_rt_dst≠0 & (ex_rt_dst==id_rs | (id_uses_rt & ex_rt_dst==id_rt)).
- mdu_stall = mdu_busy & (id_reads_hilo | id_is_mdu).
- Priority when not frozen:
  1. Branch taken: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=1. Overrides stalls, since the stalled instruction is squashed.
  2. load_use or mdu_stall: pc_we=0, ifid_we=0, idex_bubble=1.
  3. Otherwise: all enables 1, no bubbles.
- idex_we and exmem_we are 1 whenever not frozen.
- mdu_start = id_is_mdu & ~mdu_busy & ~freeze & ~ex_branch_taken & ~load_use.
- MDU counter:
  - On mdu_start: cnt ← DIV_LATENCY if id_mdu_div, else MUL_LATENCY.
  - Otherwise decrements when non-zero, including during freeze (the MDU runs independently).
  - mdu_busy = cnt≠0.
  - mdu_done = 1 in the cycle cnt goes 1→0.
  - Width is ⌈log2(max latency+1)⌉; no wrap.

## Timing
- Async reset (rst_n=0): state RUN, wait_cnt 0, MDU cnt 0, mem_timeout 0.
- While rst_n=0, outputs are forced:
  - all write enables 0;
  - ifid_flush, idex_bubble, memwb_bubble 1;
  - mdu_start, mdu_busy, mdu_done 0;
  - state 00.
- Reset mid-MDU or mid-wait clears all counters immediately.
- All stall/flush/enable outputs are combinational from current state and inputs (same-cycle effect). State, counters and mem_timeout update on the rising clk edge.
- Load-use costs exactly 1 bubble.
- An MDU op issued at cycle t:
  - mdu_busy is high for cycles t+1..t+L, where L is MUL_LATENCY or DIV_LATENCY;
  - mdu_done is high at cycle t+L;
  - a dependent mfhi in ID stalls through cycle t+L and proceeds at t+L+1.
- A mem_ready cycle releases the freeze in that same cycle.
- Simultaneous branch, load-use and not-ready memory: freeze wins; the branch is re-evaluated once unfrozen, because EX is held.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rt_dst=5, id_rs=5 → pc_we=0, ifid_we=0, idex_bubble=1 for 1 cycle. The same stimulus with ex_rt_dst=0 → no stall.
- **Branch over stall:** ex_branch_taken=1 while load_use is true → pc_we=1, ifid_flush=1, idex_bubble=1, mdu_start=0.
- **MDU interlock:** mult issued (MUL_LATENCY=4), then mfhi in ID → mdu_start pulses once, mdu_busy high 4 cycles, mfhi stalled 4 cycles, mdu_done on the 4th. Repeat with div at 32 cycles.
- **Memory wait:** mem_req=1 with mem_ready low for 3 cycles, then high → state RUN→MEM_WAIT for 2 cycles, freeze lasts 3 cycles, all enables return on the ready cycle, memwb_bubble=1 during the freeze.
- **Timeout:** MAX_WAIT=4 and mem_ready never asserted → state=HALT and mem_timeout=1 after 4 frozen cycles. Both hold until rst_n is pulsed low.
- **Reset mid-operation:** assert rst_n=0 during a div at cnt=17 → mdu_busy=0 and enables 0 immediately. After release, state=00 and cnt=0.
